// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and commit signals of the reorder buffer.
// The pipeline drives the master side; the reorder buffer sits on the slave side.
interface reorder_buffer_if #(
   parameter int ROB_WIDTH = 4
);
   logic                 readyIn;
   logic                 issueValid;
   logic                 issueHasRd;
   logic [4:0]           issueRd;
   logic                 issueIsStore;
   logic                 issueIsBranch;
   logic [ROB_WIDTH-1:0] allocId;
   logic                 full;
   logic                 cdbValid;
   logic [ROB_WIDTH-1:0] cdbId;
   logic [31:0]          cdbValue;
   logic                 cdbMispredict;
   logic [31:0]          cdbTarget;
   logic [ROB_WIDTH-1:0] queryId;
   logic                 queryReady;
   logic [31:0]          queryValue;
   logic                 writeFlag;
   logic [ROB_WIDTH-1:0] robId;
   logic [4:0]           writeAddr;
   logic [31:0]          writeValue;
   logic                 storeCommitFlag;
   logic [ROB_WIDTH-1:0] storeCommitId;
   logic                 clearOut;
   logic [31:0]          clearPC;

   modport master (
      output readyIn, issueValid, issueHasRd, issueRd, issueIsStore, issueIsBranch,
             cdbValid, cdbId, cdbValue, cdbMispredict, cdbTarget, queryId,
      input  allocId, full, queryReady, queryValue, writeFlag, robId, writeAddr,
             writeValue, storeCommitFlag, storeCommitId, clearOut, clearPC
   );

   modport slave (
      input  readyIn, issueValid, issueHasRd, issueRd, issueIsStore, issueIsBranch,
             cdbValid, cdbId, cdbValue, cdbMispredict, cdbTarget, queryId,
      output allocId, full, queryReady, queryValue, writeFlag, robId, writeAddr,
             writeValue, storeCommitFlag, storeCommitId, clearOut, clearPC
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates tags at issue, captures CDB results,
// retires one entry per cycle and flushes everything on a mispredicted branch.
module reorder_buffer #(
   parameter int ROB_WIDTH = 4
) (
   input logic             clockIn,
   input logic             resetIn,
   reorder_buffer_if.slave bus
);
   localparam int DEPTH = 1 << ROB_WIDTH;
   localparam int CW    = ROB_WIDTH + 1;

   typedef logic [ROB_WIDTH-1:0] tag_t;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_ready;
   logic [DEPTH-1:0] r_has_rd;
   logic [DEPTH-1:0] r_is_store;
   logic [DEPTH-1:0] r_is_branch;
   logic [DEPTH-1:0] r_mispredict;
   logic [4:0]       r_rd     [DEPTH];
   logic [31:0]      r_value  [DEPTH];
   logic [31:0]      r_target [DEPTH];

   tag_t             r_head;
   tag_t             r_tail;
   logic [CW-1:0]    r_count;

   logic             r_write_flag;
   tag_t             r_rob_id;
   logic [4:0]       r_write_addr;
   logic [31:0]      r_write_value;
   logic             r_store_flag;
   tag_t             r_store_id;
   logic             r_clear;
   logic [31:0]      r_clear_pc;

   logic             w_full;
   logic             w_commit;
   logic             w_flush;
   logic             w_alloc;
   logic             w_wb;
   logic             w_query_ready;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_commit = bus.readyIn && r_busy[r_head] && r_ready[r_head];
   assign w_flush  = w_commit && r_is_branch[r_head] && r_mispredict[r_head];
   // Full is judged on the pre-edge count, so a same-cycle commit never frees a slot early.
   assign w_alloc  = bus.readyIn && bus.issueValid && !w_full && !w_flush;
   assign w_wb     = bus.cdbValid && r_busy[bus.cdbId];

   assign w_query_ready  = r_busy[bus.queryId] && r_ready[bus.queryId];
   assign bus.queryReady = w_query_ready;
   assign bus.queryValue = w_query_ready ? r_value[bus.queryId] : '0;
   assign bus.allocId    = r_tail;
   assign bus.full       = w_full;

   // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         r_busy  <= '0;
         r_ready <= '0;
      end else if (w_flush) begin
         r_busy  <= '0;
      end else begin
         if (w_commit) r_busy[r_head] <= 1'b0;
         if (w_alloc) begin
            r_busy[r_tail]  <= 1'b1;
            r_ready[r_tail] <= 1'b0;
         end
         if (w_wb) r_ready[bus.cdbId] <= 1'b1;
      end
   end

   // NOTE: payload arrays carry no reset; busy/ready gate every use of their contents.
   always_ff @(posedge clockIn) begin
      if (w_alloc) begin
         r_has_rd[r_tail]     <= bus.issueHasRd;
         r_rd[r_tail]         <= bus.issueRd;
         r_is_store[r_tail]   <= bus.issueIsStore;
         r_is_branch[r_tail]  <= bus.issueIsBranch;
         r_mispredict[r_tail] <= 1'b0;
      end
      if (w_wb) begin
         r_value[bus.cdbId]      <= bus.cdbValue;
         r_mispredict[bus.cdbId] <= bus.cdbMispredict;
         r_target[bus.cdbId]     <= bus.cdbTarget;
      end
   end

   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + tag_t'(w_commit);
         r_tail  <= r_tail + tag_t'(w_alloc);
         r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
      end
   end

   // Commit outputs are single-cycle pulses; idle cycles drive every field to zero.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         r_write_flag  <= 1'b0;
         r_rob_id      <= '0;
         r_write_addr  <= '0;
         r_write_value <= '0;
         r_store_flag  <= 1'b0;
         r_store_id    <= '0;
         r_clear       <= 1'b0;
         r_clear_pc    <= '0;
      end else begin
         r_write_flag  <= w_commit && r_has_rd[r_head];
         r_rob_id      <= w_commit ? r_head : '0;
         r_write_addr  <= w_commit ? r_rd[r_head] : '0;
         r_write_value <= w_commit ? r_value[r_head] : '0;
         r_store_flag  <= w_commit && r_is_store[r_head];
         r_store_id    <= w_commit ? r_head : '0;
         r_clear       <= w_flush;
         r_clear_pc    <= w_flush ? r_target[r_head] : '0;
      end
   end

   assign bus.writeFlag       = r_write_flag;
   assign bus.robId           = r_rob_id;
   assign bus.writeAddr       = r_write_addr;
   assign bus.writeValue      = r_write_value;
   assign bus.storeCommitFlag = r_store_flag;
   assign bus.storeCommitId   = r_store_id;
   assign bus.clearOut        = r_clear;
   assign bus.clearPC         = r_clear_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order retirement, full/wrap,
// mispredict flush, store commit with stalls, and operand query timing.
module tb_reorder_buffer;
   localparam int RW = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   reorder_buffer_if #(.ROB_WIDTH(RW)) bus ();

   reorder_buffer #(.ROB_WIDTH(RW)) dut (
      .clockIn (clk),
      .resetIn (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.readyIn       = 1'b1;
      bus.issueValid    = 1'b0;
      bus.issueHasRd    = 1'b0;
      bus.issueRd       = '0;
      bus.issueIsStore  = 1'b0;
      bus.issueIsBranch = 1'b0;
      bus.cdbValid      = 1'b0;
      bus.cdbId         = '0;
      bus.cdbValue      = '0;
      bus.cdbMispredict = 1'b0;
      bus.cdbTarget     = '0;
      bus.queryId       = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic has_rd, input logic is_store,
                        input logic is_branch);
      bus.issueValid    = 1'b1;
      bus.issueHasRd    = has_rd;
      bus.issueRd       = rd;
      bus.issueIsStore  = is_store;
      bus.issueIsBranch = is_branch;
      tick();
      bus.issueValid    = 1'b0;
      bus.issueIsStore  = 1'b0;
      bus.issueIsBranch = 1'b0;
   endtask

   task automatic cdb(input logic [RW-1:0] id, input logic [31:0] value, input logic misp,
                      input logic [31:0] target);
      bus.cdbValid      = 1'b1;
      bus.cdbId         = id;
      bus.cdbValue      = value;
      bus.cdbMispredict = misp;
      bus.cdbTarget     = target;
      tick();
      bus.cdbValid      = 1'b0;
      bus.cdbMispredict = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.allocId !== 4'd0) begin failures++; $display("FAIL rst_alloc got=%0h exp=0", bus.allocId); end
      checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0h exp=0", bus.full); end
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL rst_wf got=%0h exp=0", bus.writeFlag); end
      checks++; if (bus.clearOut !== 1'b0) begin failures++; $display("FAIL rst_clear got=%0h exp=0", bus.clearOut); end
      issue(5'd1, 1'b1, 1'b0, 1'b0);
      issue(5'd2, 1'b1, 1'b0, 1'b0);
      issue(5'd3, 1'b1, 1'b0, 1'b0);
      cdb(4'd0, 32'hAA, 1'b0, 32'h0);
      cdb(4'd1, 32'hBB, 1'b0, 32'h0);
      bus.queryId = 4'd1;
      #1;
      checks++; if (bus.writeFlag !== 1'b1) begin failures++; $display("FAIL midrun_wf got=%0h exp=1", bus.writeFlag); end
      checks++; if (bus.queryReady !== 1'b1) begin failures++; $display("FAIL midrun_qr got=%0h exp=1", bus.queryReady); end
      rst = 1'b1;
      #1;
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL async_wf got=%0h exp=0", bus.writeFlag); end
      checks++; if (bus.writeAddr !== 5'd0) begin failures++; $display("FAIL async_addr got=%0h exp=0", bus.writeAddr); end
      checks++; if (bus.writeValue !== 32'd0) begin failures++; $display("FAIL async_val got=%0h exp=0", bus.writeValue); end
      checks++; if (bus.allocId !== 4'd0) begin failures++; $display("FAIL async_alloc got=%0h exp=0", bus.allocId); end
      checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL async_full got=%0h exp=0", bus.full); end
      checks++; if (bus.queryReady !== 1'b0) begin failures++; $display("FAIL async_qr got=%0h exp=0", bus.queryReady); end
      idle_inputs();
      rst = 1'b0;
      tick();
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL post_rst_wf got=%0h exp=0", bus.writeFlag); end
   endtask

   task automatic test_in_order();
      logic [4:0]  exp_addr [3];
      logic [31:0] exp_val  [3];
      exp_addr = '{5'd5, 5'd6, 5'd7};
      exp_val  = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.allocId !== 4'(i)) begin failures++; $display("FAIL io_alloc%0d got=%0h exp=%0h", i, bus.allocId, i); end
         issue(exp_addr[i], 1'b1, 1'b0, 1'b0);
      end
      cdb(4'd2, 32'h33, 1'b0, 32'h0);
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL io_early got=%0h exp=0", bus.writeFlag); end
      cdb(4'd0, 32'h11, 1'b0, 32'h0);
      cdb(4'd1, 32'h22, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         checks++; if (bus.writeFlag !== 1'b1) begin failures++; $display("FAIL io_wf%0d got=%0h exp=1", i, bus.writeFlag); end
         checks++; if (bus.robId !== 4'(i)) begin failures++; $display("FAIL io_id%0d got=%0h exp=%0h", i, bus.robId, i); end
         checks++; if (bus.writeAddr !== exp_addr[i]) begin failures++; $display("FAIL io_addr%0d got=%0h exp=%0h", i, bus.writeAddr, exp_addr[i]); end
         checks++; if (bus.writeValue !== exp_val[i]) begin failures++; $display("FAIL io_val%0d got=%0h exp=%0h", i, bus.writeValue, exp_val[i]); end
      end
      tick();
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL io_empty got=%0h exp=0", bus.writeFlag); end
      checks++; if (bus.robId !== 4'd0) begin failures++; $display("FAIL io_empty_id got=%0h exp=0", bus.robId); end
   endtask

   task automatic test_full_wrap();
      pulse_reset();
      for (int i = 0; i < 16; i++) issue(5'(i), 1'b1, 1'b0, 1'b0);
      checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fw_full got=%0h exp=1", bus.full); end
      checks++; if (bus.allocId !== 4'd0) begin failures++; $display("FAIL fw_alloc got=%0h exp=0", bus.allocId); end
      bus.issueValid = 1'b1;
      bus.issueHasRd = 1'b1;
      bus.issueRd    = 5'd31;
      tick();
      checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fw_17th got=%0h exp=1", bus.full); end
      bus.cdbValid = 1'b1;
      bus.cdbId    = 4'd0;
      bus.cdbValue = 32'h100;
      tick();
      bus.cdbValid = 1'b0;
      checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fw_wb_full got=%0h exp=1", bus.full); end
      tick();
      checks++; if (bus.writeFlag !== 1'b1) begin failures++; $display("FAIL fw_commit_wf got=%0h exp=1", bus.writeFlag); end
      checks++; if (bus.writeAddr !== 5'd0) begin failures++; $display("FAIL fw_commit_addr got=%0h exp=0", bus.writeAddr); end
      checks++; if (bus.writeValue !== 32'h100) begin failures++; $display("FAIL fw_commit_val got=%0h exp=100", bus.writeValue); end
      checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL fw_no_alloc got=%0h exp=0", bus.full); end
      checks++; if (bus.allocId !== 4'd0) begin failures++; $display("FAIL fw_wrap_id got=%0h exp=0", bus.allocId); end
      tick();
      bus.issueValid = 1'b0;
      checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fw_realloc_full got=%0h exp=1", bus.full); end
      checks++; if (bus.allocId !== 4'd1) begin failures++; $display("FAIL fw_realloc_id got=%0h exp=1", bus.allocId); end
   endtask

   task automatic test_mispredict();
      pulse_reset();
      issue(5'd10, 1'b1, 1'b0, 1'b0);
      issue(5'd11, 1'b1, 1'b0, 1'b0);
      issue(5'd12, 1'b1, 1'b0, 1'b0);
      issue(5'd1,  1'b1, 1'b0, 1'b1);
      issue(5'd13, 1'b1, 1'b0, 1'b0);
      issue(5'd14, 1'b1, 1'b0, 1'b0);
      issue(5'd15, 1'b1, 1'b0, 1'b0);
      cdb(4'd0, 32'h40, 1'b0, 32'h0);
      cdb(4'd1, 32'h41, 1'b0, 32'h0);
      cdb(4'd2, 32'h42, 1'b0, 32'h0);
      cdb(4'd3, 32'h44, 1'b1, 32'h1000);
      checks++; if (bus.clearOut !== 1'b0) begin failures++; $display("FAIL mp_pre_clear got=%0h exp=0", bus.clearOut); end
      bus.issueValid = 1'b1;
      bus.issueRd    = 5'd30;
      cdb(4'd4, 32'h55, 1'b0, 32'h0);
      bus.issueValid = 1'b0;
      checks++; if (bus.clearOut !== 1'b1) begin failures++; $display("FAIL mp_clear got=%0h exp=1", bus.clearOut); end
      checks++; if (bus.clearPC !== 32'h1000) begin failures++; $display("FAIL mp_pc got=%0h exp=1000", bus.clearPC); end
      checks++; if (bus.writeFlag !== 1'b1) begin failures++; $display("FAIL mp_wf got=%0h exp=1", bus.writeFlag); end
      checks++; if (bus.robId !== 4'd3) begin failures++; $display("FAIL mp_id got=%0h exp=3", bus.robId); end
      checks++; if (bus.writeValue !== 32'h44) begin failures++; $display("FAIL mp_val got=%0h exp=44", bus.writeValue); end
      bus.queryId = 4'd5;
      cdb(4'd5, 32'h66, 1'b0, 32'h0);
      checks++; if (bus.clearOut !== 1'b0) begin failures++; $display("FAIL mp_clear_once got=%0h exp=0", bus.clearOut); end
      checks++; if (bus.clearPC !== 32'h0) begin failures++; $display("FAIL mp_pc_once got=%0h exp=0", bus.clearPC); end
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL mp_after_wf got=%0h exp=0", bus.writeFlag); end
      checks++; if (bus.allocId !== 4'd0) begin failures++; $display("FAIL mp_alloc got=%0h exp=0", bus.allocId); end
      checks++; if (bus.queryReady !== 1'b0) begin failures++; $display("FAIL mp_dropped_cdb got=%0h exp=0", bus.queryReady); end
      bus.queryId = 4'd4;
      #1;
      checks++; if (bus.queryReady !== 1'b0) begin failures++; $display("FAIL mp_flushed4 got=%0h exp=0", bus.queryReady); end
      issue(5'd20, 1'b1, 1'b0, 1'b0);
      cdb(4'd0, 32'h77, 1'b0, 32'h0);
      tick();
      checks++; if (bus.writeFlag !== 1'b1) begin failures++; $display("FAIL mp_restart_wf got=%0h exp=1", bus.writeFlag); end
      checks++; if (bus.robId !== 4'd0) begin failures++; $display("FAIL mp_restart_id got=%0h exp=0", bus.robId); end
      checks++; if (bus.writeAddr !== 5'd20) begin failures++; $display("FAIL mp_restart_addr got=%0h exp=14", bus.writeAddr); end
      checks++; if (bus.writeValue !== 32'h77) begin failures++; $display("FAIL mp_restart_val got=%0h exp=77", bus.writeValue); end
   endtask

   task automatic test_store_ready();
      pulse_reset();
      issue(5'd9, 1'b0, 1'b1, 1'b0);
      bus.readyIn    = 1'b0;
      bus.issueValid = 1'b1;
      bus.issueRd    = 5'd8;
      cdb(4'd0, 32'h5, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         checks++; if (bus.storeCommitFlag !== 1'b0) begin failures++; $display("FAIL st_stall_sc%0d got=%0h exp=0", i, bus.storeCommitFlag); end
         checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL st_stall_wf%0d got=%0h exp=0", i, bus.writeFlag); end
      end
      checks++; if (bus.allocId !== 4'd1) begin failures++; $display("FAIL st_stall_alloc got=%0h exp=1", bus.allocId); end
      bus.readyIn    = 1'b1;
      bus.issueValid = 1'b0;
      tick();
      checks++; if (bus.storeCommitFlag !== 1'b1) begin failures++; $display("FAIL st_sc got=%0h exp=1", bus.storeCommitFlag); end
      checks++; if (bus.storeCommitId !== 4'd0) begin failures++; $display("FAIL st_id got=%0h exp=0", bus.storeCommitId); end
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL st_wf got=%0h exp=0", bus.writeFlag); end
      tick();
      checks++; if (bus.storeCommitFlag !== 1'b0) begin failures++; $display("FAIL st_pulse got=%0h exp=0", bus.storeCommitFlag); end
   endtask

   task automatic test_query();
      pulse_reset();
      for (int i = 0; i < 5; i++) issue(5'(i + 1), 1'b1, 1'b0, 1'b0);
      bus.queryId  = 4'd4;
      bus.cdbValid = 1'b1;
      bus.cdbId    = 4'd4;
      bus.cdbValue = 32'hDEAD;
      #1;
      checks++; if (bus.queryReady !== 1'b0) begin failures++; $display("FAIL q_same_rdy got=%0h exp=0", bus.queryReady); end
      checks++; if (bus.queryValue !== 32'h0) begin failures++; $display("FAIL q_same_val got=%0h exp=0", bus.queryValue); end
      tick();
      bus.cdbValid = 1'b0;
      checks++; if (bus.queryReady !== 1'b1) begin failures++; $display("FAIL q_rdy got=%0h exp=1", bus.queryReady); end
      checks++; if (bus.queryValue !== 32'hDEAD) begin failures++; $display("FAIL q_val got=%0h exp=dead", bus.queryValue); end
      bus.queryId = 4'd3;
      #1;
      checks++; if (bus.queryReady !== 1'b0) begin failures++; $display("FAIL q_other got=%0h exp=0", bus.queryReady); end
      checks++; if (bus.writeFlag !== 1'b0) begin failures++; $display("FAIL q_no_commit got=%0h exp=0", bus.writeFlag); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_in_order();
      test_full_wrap();
      test_mispredict();
      test_store_ready();
      test_query();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer with 2^ROB_WIDTH entries; the producer side of the register file's rename/commit interface.
- Hands out ROB tags (rdDest) at issue and captures results from the common data bus.
- Retires one entry per cycle in program order. Each retirement drives the register file's writeFlag/robId/writeAddr/writeValue, signals store commit, or flushes on a branch mispredict.

Parameters:
ROB_WIDTH, 4, tag width; depth = 2^ROB_WIDTH entries

Ports:
clockIn  input  1  clock
resetIn  input  1  asynchronous active-high reset
readyIn  input  1  global advance enable; low = freeze allocation and commit
issueValid  input  1  allocate an entry this cycle
issueHasRd  input  1  entry writes a register at commit
issueRd  input  5  destination register
issueIsStore  input  1  entry is a store
issueIsBranch  input  1  entry may mispredict (branch/jalr)
allocId  output  ROB_WIDTH  tag of the next free entry (tail), combinational
full  output  1  count == 2^ROB_WIDTH, combinational
cdbValid  input  1  result broadcast
cdbId  input  ROB_WIDTH  tag of the producing entry
cdbValue  input  32  result value
cdbMispredict  input  1  branch resolved wrong
cdbTarget  input  32  correct next PC
queryId  input  ROB_WIDTH  operand lookup tag
queryReady  output  1  entry busy and result captured, combinational
queryValue  output  32  captured value, combinational
writeFlag  output  1  register commit pulse
robId  output  ROB_WIDTH  committing tag
writeAddr  output  5  committing rd
writeValue  output  32  committing value
storeCommitFlag  output  1  store may drain to memory
storeCommitId  output  ROB_WIDTH  tag of the store
clearOut  output  1  pipeline flush pulse
clearPC  output  32  redirect PC

Behaviour:
- State per entry: busy, ready, hasRd, rd, isStore, isBranch, value, mispredict, target. Pointers: head and tail (ROB_WIDTH bits, natural wrap), count (ROB_WIDTH+1 bits).
- Reset (asynchronous): all busy = 0; head = tail = count = 0; every registered output = 0.
- Allocate at posedge when readyIn && issueValid && !full && !flushing.
  - Entry[tail] gets busy = 1, ready = 0, mispredict = 0, plus the issue fields.
  - tail++; allocId shows the pre-increment tail during the issue cycle.
- Writeback at posedge when cdbValid && entry[cdbId].busy: sets ready = 1 and stores value, mispredict and target. This is captured even when readyIn is low. cdbValid to a non-busy entry is ignored.
- Commit at posedge when readyIn && entry[head].busy && entry[head].ready:
  - writeFlag = hasRd; robId = head; writeAddr = rd; writeValue = value.
  - storeCommitFlag = isStore; storeCommitId = head.
  - busy[head] = 0; head++.
  - All commit outputs are registered one-cycle pulses. A cycle with no commit drives them to 0.
- Latency:
  - Writeback at edge N makes the entry eligible at edge N+1, where the commit pulse is registered.
  - The register file consumes it at edge N+2.
  - queryReady/queryValue reflect state after edge N; there is no same-cycle CDB bypass.
- Mispredict: commit of an entry with isBranch && mispredict.
  - Still performs its rd write.
  - Asserts clearOut = 1 and clearPC = target for one cycle.
  - In the same edge: all busy = 0, head = tail = count = 0.
  - Any allocation in that cycle is discarded.
  - CDB writebacks in the cycle after the flush target non-busy entries and are dropped.
- Count:
  - +1 on allocate, -1 on commit, unchanged when both occur.
  - full is computed from the pre-edge count, so a full buffer does not allocate even if it commits in the same cycle.
- Empty (count == 0): no commit; outputs pulse-low.
- readyIn low: no allocation, no commit, commit outputs 0, state held except CDB capture.

Test Plan:
- Reset mid-run with 3 entries busy → all outputs 0 immediately (async); allocId = 0, full = 0, queryReady = 0.
- Allocate tags 0,1,2 (rd 5,6,7); CDB 2=0x33, 0=0x11, 1=0x22 → writeFlag pulses in order robId 0,1,2 with writeAddr 5,6,7 and values 0x11,0x22,0x33.
- Fill 16 entries → full = 1 and the 17th issueValid is ignored. Commit entry 0 while issuing → no allocation that cycle; next cycle allocId = 0 (wrap) and allocation succeeds.
- Branch at tag 3 with cdbMispredict = 1, cdbTarget = 0x1000, entries 4-6 busy → at its commit clearOut = 1 and clearPC = 0x1000 for exactly one cycle; next cycle count = 0, allocId = 0.
- Store at tag 0 completed → storeCommitFlag = 1, storeCommitId = 0, writeFlag = 0. With readyIn held low for 3 cycles no pulses occur, and the commit happens one cycle after readyIn rises.
- queryId = 4 after CDB 4 = 0xDEAD → queryReady = 1, queryValue = 0xDEAD the cycle after capture, 0 in the capture cycle.
